uart_tx_fifo: RTL and testbench

//  Buffered 8-bit UART transmitter: the driving end of the 8N1/8E1 serial link that the bench UART model samples.

---
 rtl/uart_tx_pkg.sv | 19 +
 rtl/uart_tx_fifo_if.sv | 11 +
 rtl/uart_tx_sync_fifo.sv | 48 ++++
 rtl/uart_tx_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_tx_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte push port: valid/ready handshake into the transmit FIFO.
interface uart_tx_fifo_if import uart_tx_pkg::*; ();

    logic [UART_DATA_BITS-1:0] data;
    logic                      valid;
    logic                      ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);

endinterface

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock FIFO with an extra pointer MSB to tell full from empty.
module uart_tx_sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];
    // Full refuses a push even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage needs no reset; resetting the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Pointer update; wrap is implicit in the AW+1 bit arithmetic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1/8E1 UART transmitter: push FIFO feeding a baud-divided serialiser.
module uart_tx_fifo import uart_tx_pkg::*; #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DIV_W-1:0]            cfg_div_i,
    input  logic                        cfg_parity_en_i,
    input  logic                        cfg_stop2_i,
    uart_tx_fifo_if.slave               push_if,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o
);

    localparam logic [DIV_W-1:0] CNT_ONE = 1;

    uart_tx_state_e            state;
    logic [DIV_W-1:0]          cnt;
    logic [DIV_W-1:0]          div_l;
    logic                      par_en_l;
    logic                      stop2_l;
    logic                      stop_2nd;
    logic                      par_bit;
    logic [2:0]                bit_cnt;
    logic [UART_DATA_BITS-1:0] shift;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] head;
    logic                      bit_end;
    logic                      frame_done;
    logic                      pop;

    assign push_if.ready = !fifo_full;
    assign bit_end       = (cnt == '0);
    assign frame_done    = (state == STOP) && bit_end && (!stop2_l || stop_2nd);
    // Pop from IDLE, or at the end of the last stop bit for gapless back-to-back frames.
    assign pop           = !fifo_empty && ((state == IDLE) || frame_done);
    assign busy_o        = (state != IDLE) || !fifo_empty;

    uart_tx_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_if.valid),
        .wdata (push_if.data),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

    // Frame FSM with baud down-counter; tx_o is a flop so the pad never sees a glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_o     <= 1'b1;
            cnt      <= '0;
            div_l    <= '0;
            par_en_l <= 1'b0;
            stop2_l  <= 1'b0;
            stop_2nd <= 1'b0;
            par_bit  <= 1'b0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_o <= 1'b1;
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        tx_o    <= shift[0];
                        cnt     <= div_l;
                        bit_cnt <= '0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= div_l;
                        if (bit_cnt == 3'd7) begin
                            stop_2nd <= 1'b0;
                            if (par_en_l) begin
                                state <= PARITY;
                                tx_o  <= par_bit;
                            end else begin
                                state <= STOP;
                                tx_o  <= 1'b1;
                            end
                        end else begin
                            shift   <= shift >> 1;
                            tx_o    <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        tx_o     <= 1'b1;
                        cnt      <= div_l;
                        stop_2nd <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop2_l && !stop_2nd) begin
                            stop_2nd <= 1'b1;
                            cnt      <= div_l;
                        end else begin
                            state <= IDLE;
                            tx_o  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_o  <= 1'b1;
                end
            endcase

            // Frame start overrides the above: take the head byte and freeze the config.
            if (pop) begin
                state    <= START;
                tx_o     <= 1'b0;
                shift    <= head;
                par_bit  <= even_parity(head);
                div_l    <= cfg_div_i;
                cnt      <= cfg_div_i;
                par_en_l <= cfg_parity_en_i;
                stop2_l  <= cfg_stop2_i;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: serial receiver samples every cycle of each bit period.
module tb_uart_tx_fifo;

    logic        clk;
    logic        rst_n;
    logic [15:0] cfg_div;
    logic        cfg_par;
    logic        cfg_stop2;
    logic        tx;
    logic        busy;
    logic [4:0]  level;

    int total = 0;
    int bad   = 0;

    logic [7:0] got [17];
    int         wt  [17];
    logic [7:0] d0, d1;
    logic       p0, p1;
    int         w0, w1;
    int         lows;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(.FIFO_DEPTH(16), .DIV_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_div_i       (cfg_div),
        .cfg_parity_en_i (cfg_par),
        .cfg_stop2_i     (cfg_stop2),
        .push_if         (bus),
        .tx_o            (tx),
        .busy_o          (busy),
        .level_o         (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input logic [7:0] d);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.data  = d;
        @(negedge clk);
        bus.valid = 1'b0;
    endtask

    // Waits for a start bit, then samples every cycle of every bit period.
    // Returns at the negedge following the last stop-bit cycle.
    task automatic rx_frame(input int div, input bit par, input bit stop2,
                            output logic [7:0] data, output logic pbit, output int wait_cyc);
        int w = 0;
        int nb;
        logic [11:0] bits = '0;
        logic unstable = 1'b0;
        logic first;
        while (tx !== 1'b0 && w < 20000) begin
            @(negedge clk);
            w++;
        end
        wait_cyc = w;
        data = '0;
        pbit = 1'b0;
        if (tx !== 1'b0) begin
            chk("rx_timeout", 1, 0);
            return;
        end
        nb = 10 + int'(par) + int'(stop2);
        for (int b = 0; b < nb; b++) begin
            first = tx;
            for (int c = 0; c <= div; c++) begin
                if (tx !== first) unstable = 1'b1;
                @(negedge clk);
            end
            bits[b] = first;
        end
        chk("bit_stable", unstable, 0);
        chk("start_bit", bits[0], 0);
        chk("stop_bit", bits[9 + int'(par)], 1);
        if (stop2) chk("stop2_bit", bits[10 + int'(par)], 1);
        data = bits[8:1];
        pbit = par ? bits[9] : 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.valid = 1'b0;
        bus.data  = '0;
        cfg_div   = 16'd31;
        cfg_par   = 1'b0;
        cfg_stop2 = 1'b0;
        #23;
        chk("rst_tx", tx, 1);
        chk("rst_ready", bus.ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 8N1 0x55, div 31: start at N+2, 32-cycle bits
        push_one(8'h55);
        chk("lvl_after_push", level, 1);
        chk("tx_idle_n1", tx, 1);
        chk("busy_after_push", busy, 1);
        rx_frame(31, 0, 0, d0, p0, w0);
        chk("b55_data", d0, 8'h55);
        chk("b55_latency", w0, 1);
        chk("b55_busy_end", busy, 0);

        // 8E1: 0x07 -> parity 1, 0x03 -> parity 0, back-to-back
        cfg_par = 1'b1;
        fork
            begin push_one(8'h07); push_one(8'h03); end
            begin
                rx_frame(31, 1, 0, d0, p0, w0);
                rx_frame(31, 1, 0, d1, p1, w1);
            end
        join
        chk("p07_data", d0, 8'h07);
        chk("p07_par", p0, 1);
        chk("p03_data", d1, 8'h03);
        chk("p03_par", p1, 0);
        chk("p03_gap", w1, 0);
        cfg_par = 1'b0;

        // 18 pushes on consecutive cycles: one popped, 16 stored, last dropped
        cfg_div = 16'd7;
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    bus.valid = 1'b1;
                    bus.data  = 8'(8'h10 + i);
                    @(negedge clk);
                end
                bus.valid = 1'b0;
                chk("burst_level", level, 16);
                chk("burst_ready", bus.ready, 0);
            end
            begin
                for (int i = 0; i < 17; i++) rx_frame(7, 0, 0, got[i], p0, wt[i]);
            end
        join
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("burst_data%0d", i), got[i], 8'(8'h10 + i));
            if (i > 0) chk($sformatf("burst_gap%0d", i), wt[i], 0);
        end
        lows = 0;
        for (int c = 0; c < 200; c++) begin
            if (tx !== 1'b1) lows++;
            @(negedge clk);
        end
        chk("burst_no_extra", lows, 0);
        chk("burst_busy_end", busy, 0);

        // div 0, two stop bits: 11-cycle frames, checked back-to-back
        cfg_div   = 16'd0;
        cfg_stop2 = 1'b1;
        fork
            begin push_one(8'hA3); push_one(8'h3C); end
            begin
                rx_frame(0, 0, 1, d0, p0, w0);
                rx_frame(0, 0, 1, d1, p1, w1);
            end
        join
        chk("a3_data", d0, 8'hA3);
        chk("3c_data", d1, 8'h3C);
        chk("3c_gap", w1, 0);
        cfg_stop2 = 1'b0;

        // Divisor change mid-frame applies from the next frame
        cfg_div = 16'd31;
        push_one(8'hC6);
        fork
            begin
                push_one(8'h5A);
                repeat (50) @(negedge clk);
                cfg_div = 16'd15;
            end
            begin
                rx_frame(31, 0, 0, d0, p0, w0);
                rx_frame(15, 0, 0, d1, p1, w1);
            end
        join
        chk("div_f1_data", d0, 8'hC6);
        chk("div_f2_data", d1, 8'h5A);
        chk("div_f2_gap", w1, 0);

        // Reset during DATA of 0xFF with bytes still queued
        cfg_div = 16'd31;
        push_one(8'hFF);
        push_one(8'hFF);
        push_one(8'hFF);
        repeat (60) @(negedge clk);
        chk("pre_rst_level", level, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", bus.ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int c = 0; c < 400; c++) begin
            if (tx !== 1'b1) lows++;
            @(negedge clk);
        end
        chk("post_rst_quiet", lows, 0);
        chk("post_rst_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
